mem_stage_sram_ctrl: RTL

Sequences data-memory accesses for the MEM stage against an external 16-bit asynchronous SRAM. Accepts one 32-bit load/store per instruction and splits it into two 16-bit half-word accesses with programmable wait states. Drives ready low while an access is in flight; the hazard/freeze logic uses ~ready to stall IF/ID/EX/MEM. Returns the assembled 32-bit read value for the MEM stage pipeline register.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 31 +++
 rtl/mem_stage_sram_ctrl_sram_addr_map.sv | 17 +
 rtl/mem_stage_sram_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

    localparam int unsigned SRAM_DW       = 16;
    localparam int unsigned CPU_DW        = 32;
    localparam int unsigned DEF_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Latched request payload: operation and full store word
    typedef struct packed {
        op_t               op;
        logic [CPU_DW-1:0] data;
    } req_t;

    // Wait counter width; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_addr_map.sv
// Translates a CPU byte address into an SRAM word index (half-word pair).
module sram_addr_map
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic [31:0]       address,
    output logic [ADDR_W-2:0] idx_c
);

    // Offset from base, drop byte offset, wrap to the index width
    always_comb begin
        idx_c = (ADDR_W-1)'((address - 32'(BASE_ADDR)) >> 2);
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses with wait states.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                ready,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_out,
    input  logic [SRAM_DW-1:0]  sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    localparam int unsigned IDX_W = ADDR_W - 1;
    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    req_t                 req_q, req_d;
    logic [31:0]          read_data_d;
    logic [ADDR_W-1:0]    sram_addr_d;
    logic [SRAM_DW-1:0]   sram_dq_out_d;
    logic                 sram_dq_oe_d;
    logic                 sram_we_n_d;
    logic [IDX_W-1:0]     idx_c;
    logic                 half_last;

    sram_addr_map #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_map (
        .address (address),
        .idx_c   (idx_c)
    );

    // Stall the pipeline unless idle with no request, or finishing this cycle
    assign ready = ((state_q == ST_IDLE) && !rd_en && !wr_en) || (state_q == ST_DONE);

    // State register, counter, latched request and registered SRAM/load outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            req_q       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            read_data   <= read_data_d;
            sram_addr   <= sram_addr_d;
            sram_dq_out <= sram_dq_out_d;
            sram_dq_oe  <= sram_dq_oe_d;
            sram_we_n   <= sram_we_n_d;
        end
    end

    // Next state and next registered outputs; bus values are set up one cycle ahead
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        req_d         = req_q;
        read_data_d   = read_data;
        sram_addr_d   = sram_addr;
        sram_dq_out_d = sram_dq_out;
        sram_dq_oe_d  = sram_dq_oe;
        sram_we_n_d   = sram_we_n;
        half_last     = (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (rd_en || wr_en) begin
                    state_d       = ST_LOW;
                    cnt_d         = '0;
                    idx_d         = idx_c;
                    req_d.op      = wr_en ? OP_WRITE : OP_READ;
                    req_d.data    = write_data;
                    sram_addr_d   = {idx_c, 1'b0};
                    sram_dq_out_d = write_data[15:0];
                    sram_dq_oe_d  = wr_en;
                    sram_we_n_d   = !wr_en;
                end
            end
            ST_LOW: begin
                if (half_last) begin
                    state_d       = ST_HIGH;
                    cnt_d         = '0;
                    sram_addr_d   = {idx_q, 1'b1};
                    sram_dq_out_d = req_q.data[31:16];
                    if (req_q.op == OP_READ) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (half_last) begin
                    state_d      = ST_DONE;
                    cnt_d        = '0;
                    sram_dq_oe_d = 1'b0;
                    sram_we_n_d  = 1'b1;
                    if (req_q.op == OP_READ) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
